// File: rtl/alu_unit_dispatcher.sv
// Registered ALU command dispatcher: one command in flight, one-hot unit enable held until
// the selected unit reports done or the timeout expires, then a single-cycle result strobe.
module alu_unit_dispatcher #(
  parameter int NUM_UNITS = 4,
  parameter int SEL_W     = 2,
  parameter int DATA_W    = 16,
  parameter int TIMEOUT   = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [SEL_W-1:0]            cmd_sel,
  output logic [NUM_UNITS-1:0]        unit_en,
  input  logic [NUM_UNITS-1:0]        unit_done,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_result,
  output logic                        res_valid,
  output logic [DATA_W-1:0]           res_data,
  output logic                        res_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_UNITS-1:0]  unit_en_q, unit_en_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_W-1:0]     res_data_q, res_data_d;
  logic                  res_err_q, res_err_d;
  logic [31:0]           cmd_sel_ext;

  assign cmd_sel_ext = 32'(cmd_sel);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      unit_en_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      unit_en_q   <= unit_en_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    unit_en_d   = unit_en_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_sel_ext < NUM_UNITS) begin
            sel_d     = cmd_sel;
            unit_en_d = {{(NUM_UNITS-1){1'b0}}, 1'b1} << cmd_sel;
            cnt_d     = '0;
            state_d   = BUSY;
          end else begin
            // Out-of-range select is answered immediately without touching any unit.
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
            res_data_d  = '0;
          end
        end
      end
      BUSY: begin
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
        // Done is checked first so a completion on the last allowed cycle still succeeds.
        if (unit_done[sel_q]) begin
          res_valid_d = 1'b1;
          res_err_d   = 1'b0;
          res_data_d  = unit_result[sel_q*DATA_W +: DATA_W];
          unit_en_d   = '0;
          state_d     = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          res_data_d  = '0;
          unit_en_d   = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign unit_en   = unit_en_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_unit_dispatcher.sv
// Directed bench for alu_unit_dispatcher: a 4-unit instance plus a 3-unit instance for illegal selects.
module tb_alu_unit_dispatcher;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_sel;
  logic [3:0]  unit_en;
  logic [3:0]  unit_done;
  logic [63:0] unit_result;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_err;

  logic        cmd_valid3;
  logic        cmd_ready3;
  logic [1:0]  cmd_sel3;
  logic [2:0]  unit_en3;
  logic [2:0]  unit_done3;
  logic [47:0] unit_result3;
  logic        res_valid3;
  logic [15:0] res_data3;
  logic        res_err3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  alu_unit_dispatcher #(.NUM_UNITS(4), .SEL_W(2), .DATA_W(16), .TIMEOUT(8)) u_dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .unit_en(unit_en), .unit_done(unit_done), .unit_result(unit_result),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err)
  );

  alu_unit_dispatcher #(.NUM_UNITS(3), .SEL_W(2), .DATA_W(16), .TIMEOUT(8)) u_dut3 (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_sel(cmd_sel3),
    .unit_en(unit_en3), .unit_done(unit_done3), .unit_result(unit_result3),
    .res_valid(res_valid3), .res_data(res_data3), .res_err(res_err3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    cmd_valid = 1'b0; cmd_sel = '0; unit_done = '0; unit_result = '0;
    cmd_valid3 = 1'b0; cmd_sel3 = '0; unit_done3 = '0; unit_result3 = '0;

    #12;
    check("rst_unit_en",   32'(unit_en), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_data",  32'(res_data), 32'h0);
    check("rst_res_err",   32'(res_err), 32'h0);
    tick();
    RST = 1'b0;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);

    // Basic dispatch to unit 2, done three cycles after accept.
    unit_result[2*16 +: 16] = 16'hA5A5;
    cmd_valid = 1'b1; cmd_sel = 2'd2;
    tick();
    cmd_valid = 1'b0;
    check("t1_en_c1",    32'(unit_en), 32'h4);
    check("t1_ready_c1", 32'(cmd_ready), 32'h0);
    tick();
    check("t1_en_c2",    32'(unit_en), 32'h4);
    tick();
    check("t1_en_c3",    32'(unit_en), 32'h4);
    check("t1_nores_c3", 32'(res_valid), 32'h0);
    unit_done = 4'b0100;
    tick();
    unit_done = '0;
    check("t1_res_valid", 32'(res_valid), 32'h1);
    check("t1_res_data",  32'(res_data), 32'hA5A5);
    check("t1_res_err",   32'(res_err), 32'h0);
    check("t1_en_off",    32'(unit_en), 32'h0);
    check("t1_ready",     32'(cmd_ready), 32'h1);
    tick();
    check("t1_valid_drop", 32'(res_valid), 32'h0);
    check("t1_data_hold",  32'(res_data), 32'hA5A5);

    // 3-unit instance: legal command with minimum latency, then an illegal select.
    unit_result3[2*16 +: 16] = 16'h7777;
    cmd_valid3 = 1'b1; cmd_sel3 = 2'd2;
    tick();
    cmd_valid3 = 1'b0;
    check("n3_en", 32'(unit_en3), 32'h4);
    unit_done3 = 3'b100;
    tick();
    unit_done3 = '0;
    check("n3_res_valid", 32'(res_valid3), 32'h1);
    check("n3_res_data",  32'(res_data3), 32'h7777);
    cmd_valid3 = 1'b1; cmd_sel3 = 2'd3;
    tick();
    cmd_valid3 = 1'b0;
    check("ill_res_valid", 32'(res_valid3), 32'h1);
    check("ill_res_err",   32'(res_err3), 32'h1);
    check("ill_res_data",  32'(res_data3), 32'h0);
    check("ill_unit_en",   32'(unit_en3), 32'h0);
    check("ill_ready",     32'(cmd_ready3), 32'h1);
    tick();
    check("ill_valid_drop", 32'(res_valid3), 32'h0);
    check("ill_unit_en_2",  32'(unit_en3), 32'h0);

    // Timeout on unit 1: enable held for 8 cycles, then error result.
    unit_result[1*16 +: 16] = 16'h1111;
    cmd_valid = 1'b1; cmd_sel = 2'd1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("to_en_%0d", i), 32'(unit_en), 32'h2);
      check($sformatf("to_nores_%0d", i), 32'(res_valid), 32'h0);
      tick();
    end
    check("to_res_valid", 32'(res_valid), 32'h1);
    check("to_res_err",   32'(res_err), 32'h1);
    check("to_res_data",  32'(res_data), 32'h0);
    check("to_en_off",    32'(unit_en), 32'h0);
    check("to_ready",     32'(cmd_ready), 32'h1);
    tick();

    // Done on the 8th BUSY cycle coincides with the timeout: done wins.
    unit_result[3*16 +: 16] = 16'h0033;
    cmd_valid = 1'b1; cmd_sel = 2'd3;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("co_en_last", 32'(unit_en), 32'h8);
    unit_done = 4'b1000;
    tick();
    unit_done = '0;
    check("co_res_valid", 32'(res_valid), 32'h1);
    check("co_res_err",   32'(res_err), 32'h0);
    check("co_res_data",  32'(res_data), 32'h0033);
    tick();

    // Done from non-selected units is ignored while idle.
    unit_done = 4'b1111;
    tick();
    unit_done = '0;
    check("idle_done_nores", 32'(res_valid), 32'h0);
    check("idle_done_noen",  32'(unit_en), 32'h0);

    // Wrong-unit done ignored while busy, then back-to-back command in the result cycle.
    unit_result[0*16 +: 16] = 16'h1234;
    unit_result[1*16 +: 16] = 16'hBEEF;
    cmd_valid = 1'b1; cmd_sel = 2'd0;
    tick();
    cmd_valid = 1'b0;
    unit_done = 4'b1000;
    tick();
    check("wu_en",    32'(unit_en), 32'h1);
    check("wu_nores", 32'(res_valid), 32'h0);
    unit_done = 4'b0001;
    tick();
    unit_done = '0;
    check("b2b_res_valid", 32'(res_valid), 32'h1);
    check("b2b_res_data",  32'(res_data), 32'h1234);
    check("b2b_ready",     32'(cmd_ready), 32'h1);
    check("b2b_en_gap",    32'(unit_en), 32'h0);
    cmd_valid = 1'b1; cmd_sel = 2'd1;
    tick();
    cmd_valid = 1'b0;
    check("b2b_en_new",    32'(unit_en), 32'h2);
    check("b2b_valid_off", 32'(res_valid), 32'h0);
    unit_done = 4'b0010;
    tick();
    unit_done = '0;
    check("b2b2_res_valid", 32'(res_valid), 32'h1);
    check("b2b2_res_data",  32'(res_data), 32'hBEEF);
    tick();

    // Asynchronous reset while unit 3 is enabled.
    cmd_valid = 1'b1; cmd_sel = 2'd3;
    tick();
    cmd_valid = 1'b0;
    check("ar_en_before", 32'(unit_en), 32'h8);
    #3;
    RST = 1'b1;
    #1;
    check("ar_en_async",    32'(unit_en), 32'h0);
    check("ar_valid_async", 32'(res_valid), 32'h0);
    tick();
    RST = 1'b0;
    #1;
    check("ar_ready", 32'(cmd_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ar_nostale_%0d", i), 32'(res_valid), 32'h0);
      check($sformatf("ar_en_idle_%0d", i), 32'(unit_en), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_unit_dispatcher.md
Name: alu_unit_dispatcher

Overview:
- Parametrised, registered successor to the combinational ALU function decoder.
- Accepts one ALU command at a time over a valid/ready handshake and raises a one-hot enable to the selected functional unit (arith, logic, cmp, shift, ...).
- Holds the enable until that unit reports done or a timeout expires, then returns the unit's result with an error flag.
- Unselected units see enable low in every cycle, which makes the enables suitable for clock-gating.

Parameters:
- NUM_UNITS, 4, number of functional units; legal range 2..16.
- SEL_W, 2, width of cmd_sel; must satisfy 2**SEL_W >= NUM_UNITS.
- DATA_W, 16, result width per unit.
- TIMEOUT, 8, maximum BUSY cycles before a timeout error; legal range 2..255.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  dispatcher can accept a command.
- cmd_sel  in  SEL_W  index of the target unit.
- unit_en  out  NUM_UNITS  one-hot enable to the units.
- unit_done  in  NUM_UNITS  per-unit completion strobe.
- unit_result  in  NUM_UNITS*DATA_W  packed results; unit i occupies bits [i*DATA_W +: DATA_W].
- res_valid  out  1  single-cycle result strobe.
- res_data  out  DATA_W  captured result; 0 on error.
- res_err  out  1  qualifies res_valid: 1 means illegal select or timeout.

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE, unit_en=0, res_valid=0, res_data=0, res_err=0, timeout counter=0, sel_q=0. cmd_ready=1 once RST deasserts.
- All outputs except cmd_ready are registered. cmd_ready = (state==IDLE), decoded from registered state only.
- FSM has two states: IDLE and BUSY.
- IDLE, cmd_valid=1, cmd_sel < NUM_UNITS:
  - accept at that edge;
  - sel_q <= cmd_sel, unit_en <= (1 << cmd_sel), counter <= 0, next state BUSY.
- IDLE, cmd_valid=1, cmd_sel >= NUM_UNITS:
  - accept;
  - next cycle res_valid=1, res_err=1, res_data=0;
  - unit_en stays 0, state stays IDLE.
- IDLE, cmd_valid=0: no change; unit_en stays 0.
- BUSY:
  - cmd_ready=0; cmd_valid is ignored.
  - counter increments by 1 per cycle, saturating at TIMEOUT-1.
  - unit_done[sel_q]=1 at an edge: res_data <= unit_result slice sel_q, res_valid <= 1, res_err <= 0, unit_en <= 0, state <= IDLE.
  - No done and counter==TIMEOUT-1: res_valid <= 1, res_err <= 1, res_data <= 0, unit_en <= 0, state <= IDLE.
  - Done and timeout on the same edge: done wins, result is returned with res_err=0.
  - unit_done bits of non-selected units are ignored in all states, including IDLE.
- Latency:
  - accept edge k → unit_en high from cycle k+1;
  - done sampled at edge m → res_valid high for exactly cycle m+1, unit_en low from m+1;
  - minimum command-to-result is 2 cycles (done in the first BUSY cycle).
- Timeout: with no done, res_valid/res_err assert TIMEOUT cycles after unit_en rises.
- Back-to-back: the result cycle is already IDLE with cmd_ready=1, so a new command may be accepted in that same cycle. res_valid of the old result and unit_en of the new command never overlap on the same unit incorrectly.
- res_data and res_err hold their last values after res_valid drops, until the next result.
- Reset asserted mid-BUSY: unit_en drops to 0 immediately (asynchronous), no res_valid is produced, and the in-flight command is lost.
- unit_en is always one-hot or zero; it is never multi-hot.

Test Plan:
- Reset, then cmd_sel=2 with cmd_valid for 1 cycle; unit_done[2] 3 cycles later with slice 2=16'hA5A5 → unit_en=4'b0100 for 3 cycles, then res_valid=1 for 1 cycle, res_data=16'hA5A5, res_err=0, unit_en=0.
- Illegal select: NUM_UNITS=3, SEL_W=2, cmd_sel=3 → res_valid=1 and res_err=1 next cycle, res_data=0, unit_en stays 3'b000, cmd_ready stays 1.
- Timeout: cmd_sel=1, never assert done, TIMEOUT=8 → unit_en=4'b0010 for 8 cycles, then res_valid=1, res_err=1, res_data=0, FSM back in IDLE.
- Done and timeout coincide: done on the 8th BUSY cycle with slice=16'h0033 → res_err=0, res_data=16'h0033.
- Wrong-unit done plus back-to-back: in BUSY for sel 0, pulse unit_done[3] → no effect. Then assert unit_done[0] and issue cmd_sel=1 in the result cycle → res_valid for unit 0 result, then unit_en=4'b0010 in the following cycle.
- Asynchronous reset mid-BUSY: assert RST between clock edges while unit_en=4'b1000 → unit_en=0 and res_valid=0 immediately; after release cmd_ready=1 and no stale result appears.
